pipeline_hazard_unit: RTL
=========================

Name: pipeline_hazard_unit

Overview:
- Parametrised hazard and forwarding controller for the 5-stage RV64 pipeline.
- Replaces the stub forwarding_unit; stall and flush decisions are no longer left to the ID stage.
- Keeps a shift-register scoreboard of in-flight instructions (EX onward) and uses it to drive:
  - EX operand forward selects,
  - load-use stalls,
  - branch-redirect flushes,
  - a whole-pipeline freeze when data memory is not ready.
- Exposes saturating stall/flush performance counters.

Parameters:
- REG_AW, 5, register-address width.
- FWD_DEPTH, 2, number of post-EX stages tracked as forward sources (1 = EX/MEM, 2 = MEM/WB, ...). Minimum 1.
- LOAD_STAGE, 2, first tracked stage index at which load data may be forwarded. Range 1..FWD_DEPTH.
- CNT_W, 32, performance counter width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- dec_valid  in  1  ID stage holds a real instruction
- dec_rs1  in  REG_AW  ID source 1 address
- dec_rs2  in  REG_AW  ID source 2 address
- dec_use_rs1  in  1  ID instruction reads rs1
- dec_use_rs2  in  1  ID instruction reads rs2
- dec_rd  in  REG_AW  ID destination address
- dec_reg_write  in  1  ID instruction writes rd
- dec_mem_read  in  1  ID instruction is a load
- ex_redirect  in  1  EX resolved a taken branch/jump this cycle
- mem_ready  in  1  data memory can accept or return this cycle
- pc_write  out  1  PC may update
- ifid_write  out  1  IF/ID may load
- ifid_flush  out  1  IF/ID loads a NOP
- idex_bubble  out  1  ID/EX loads a bubble (all control zero)
- forward_a  out  $clog2(FWD_DEPTH+1)  EX rs1 source: 0 = register file, k = tracked stage k
- forward_b  out  $clog2(FWD_DEPTH+1)  EX rs2 source, same encoding
- stall_cnt  out  CNT_W  load-use stall cycles
- flush_cnt  out  CNT_W  redirect flushes

Behaviour:
- Scoreboard: entries 0..FWD_DEPTH. Entry 0 = instruction in EX, entry k = k stages later.
  - Fields per entry: valid, rd, reg_write, is_load, rs1, rs2, use_rs1, use_rs2.
- Reset (async): all entries valid=0, counters 0.
  - Outputs after reset: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, forward_a=forward_b=0.
- Producer match for source s against entry j: entry j valid & reg_write & rd==s & rd!=0.
- Forwarding (combinational from scoreboard): for each entry-0 source with its use bit set, the result is the lowest k in 1..FWD_DEPTH that matches; 0 if none.
  - The nearest producer wins.
  - A load entry at k < LOAD_STAGE is never selected.
- Load-use stall: dec_valid, and a used dec source matches an entry j with is_load where j+1 < LOAD_STAGE. With defaults this means j = 0 only.
  - Stall response: pc_write=0, ifid_write=0, idex_bubble=1.
- Redirect: ex_redirect=1 gives ifid_flush=1 and idex_bubble=1, with pc_write=1 and ifid_write=1.
  - Redirect overrides stall; stall_cnt does not increment in that cycle.
- Freeze: mem_ready=0 gives pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=0.
  - Scoreboard and counters hold.
  - Forward selects still reflect the held scoreboard.
  - A stall or redirect during freeze is evaluated again once mem_ready returns.
- Shift (each non-frozen edge): entry[k] <= entry[k-1] for k ≥ 1.
  - entry[0] <= decode fields if dec_valid & !stall & !ex_redirect; otherwise entry[0].valid <= 0.
  - The oldest entry drops out. The register file is write-before-read, so no tracking is needed past FWD_DEPTH.
- Counters: stall_cnt +1 per non-frozen stall cycle; flush_cnt +1 per non-frozen redirect cycle. Both saturate at all-ones.
- Reset mid-operation clears the scoreboard immediately. There is no replay.

Decomposition:
- Shared package pipeline_pkg holds:
  - the scoreboard-entry struct,
  - FWD_SEL_RF = 0,
  - NOP encoding 32'h00000013.
- Natural sub-module: sat_counter (CNT_W, inc, rst), instantiated twice.

Test Plan:
- Back-to-back ALU producers: add x5 then sub x6,x5,x7 → forward_a=1 while the sub is in EX; with one independent instruction between them, forward_a=2.
- Double producer: x5 written by two consecutive instructions, consumer next → forward_a=1, so the newest value wins.
- Load-use: ld x5 then add x6,x5,x1 → exactly one cycle of pc_write=0, ifid_write=0, idex_bubble=1; then forward_a=2; stall_cnt=1.
- x0 and unused sources: producer rd=0, or consumer with dec_use_rs2=0 → forward 0, no stall.
- Redirect during a load-use stall: ex_redirect=1 in the same cycle → ifid_flush=1, pc_write=1, stall_cnt unchanged, flush_cnt +1.
- Freeze: mem_ready=0 for 3 cycles during a forwarding window → pc_write=0, selects constant, counters hold; normal flow resumes on the cycle after mem_ready returns to 1.
- Reset asserted mid-stream → all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the RV64 pipeline control logic.
// Scoreboard entries describe one in-flight instruction from EX onward.
package pipeline_pkg;

  localparam int SB_AW = 5;
  localparam int FWD_SEL_RF = 0;
  localparam logic [31:0] NOP_INSN = 32'h00000013;

  typedef struct packed {
    logic             valid;
    logic [SB_AW-1:0] rd;
    logic             reg_write;
    logic             is_load;
    logic [SB_AW-1:0] rs1;
    logic [SB_AW-1:0] rs2;
    logic             use_rs1;
    logic             use_rs2;
  } sb_entry_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-high reset.
// Stops at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Hazard and forwarding controller for the 5-stage RV64 pipeline.
// A shift-register scoreboard of EX-onward instructions drives all decisions.
module pipeline_hazard_unit
  import pipeline_pkg::*;
#(
  parameter  int REG_AW     = 5,
  parameter  int FWD_DEPTH  = 2,
  parameter  int LOAD_STAGE = 2,
  parameter  int CNT_W      = 32,
  localparam int FSW        = $clog2(FWD_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dec_valid,
  input  logic [REG_AW-1:0] dec_rs1,
  input  logic [REG_AW-1:0] dec_rs2,
  input  logic              dec_use_rs1,
  input  logic              dec_use_rs2,
  input  logic [REG_AW-1:0] dec_rd,
  input  logic              dec_reg_write,
  input  logic              dec_mem_read,
  input  logic              ex_redirect,
  input  logic              mem_ready,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic [FSW-1:0]    forward_a,
  output logic [FSW-1:0]    forward_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  sb_entry_t r_sb [0:FWD_DEPTH];
  sb_entry_t w_dec;
  logic      w_stall;
  logic      w_stall_inc;
  logic      w_flush_inc;

  function automatic logic hit(sb_entry_t e, logic [SB_AW-1:0] s);
    return e.valid && e.reg_write && (e.rd == s) && (e.rd != '0);
  endfunction

  always_comb begin
    w_dec           = '0;
    w_dec.valid     = 1'b1;
    w_dec.rd        = SB_AW'(dec_rd);
    w_dec.reg_write = dec_reg_write;
    w_dec.is_load   = dec_mem_read;
    w_dec.rs1       = SB_AW'(dec_rs1);
    w_dec.rs2       = SB_AW'(dec_rs2);
    w_dec.use_rs1   = dec_use_rs1;
    w_dec.use_rs2   = dec_use_rs2;
  end

  // Walk oldest to newest so the nearest eligible producer wins.
  always_comb begin
    forward_a = FSW'(FWD_SEL_RF);
    forward_b = FSW'(FWD_SEL_RF);
    for (int k = FWD_DEPTH; k >= 1; k--) begin
      if ((k >= LOAD_STAGE) || !r_sb[k].is_load) begin
        if (r_sb[0].valid && r_sb[0].use_rs1 &&
            hit(r_sb[k], r_sb[0].rs1))
          forward_a = FSW'(k);
        if (r_sb[0].valid && r_sb[0].use_rs2 &&
            hit(r_sb[k], r_sb[0].rs2))
          forward_b = FSW'(k);
      end
    end
  end

  always_comb begin
    w_stall = 1'b0;
    for (int j = 0; j <= FWD_DEPTH; j++) begin
      if ((j + 1 < LOAD_STAGE) && r_sb[j].is_load) begin
        if ((dec_use_rs1 && hit(r_sb[j], w_dec.rs1)) ||
            (dec_use_rs2 && hit(r_sb[j], w_dec.rs2)))
          w_stall = 1'b1;
      end
    end
    w_stall = w_stall && dec_valid;
  end

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (!mem_ready) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if (ex_redirect) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (w_stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  assign w_stall_inc = mem_ready && w_stall && !ex_redirect;
  assign w_flush_inc = mem_ready && ex_redirect;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k <= FWD_DEPTH; k++)
        r_sb[k] <= '0;
    end else if (mem_ready) begin
      for (int k = 1; k <= FWD_DEPTH; k++)
        r_sb[k] <= r_sb[k-1];
      if (dec_valid && !w_stall && !ex_redirect)
        r_sb[0] <= w_dec;
      else
        r_sb[0] <= '0;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_stall_inc),
    .cnt (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (w_flush_inc),
    .cnt (flush_cnt)
  );

endmodule
